alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_pkg.sv | 23 ++
 rtl/alu_issue_stage_alu.sv | 57 +++++
 rtl/alu_issue_stage.sv | 171 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage and its combinational ALU.
// Contents:
//   AluDataWidth - default operand/result width
//   alu_op_e     - ALUop encodings (AND, OR, ADD, SUB, SLT)
//   is_alu_op    - true when a 3-bit code is one of the defined operations
package alu_issue_stage_pkg;

    localparam int unsigned AluDataWidth = 32;

    typedef enum logic [2:0] {
        AluAnd = 3'b000,
        AluOr  = 3'b001,
        AluAdd = 3'b010,
        AluSub = 3'b110,
        AluSlt = 3'b111
    } alu_op_e;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == AluAnd) || (op == AluOr) || (op == AluAdd) ||
               (op == AluSub) || (op == AluSlt);
    endfunction

endpackage

// File: rtl/alu_issue_stage_alu.sv
// Combinational ALU used by the issue stage.
// Ports:
//   a_i, b_i    - operands
//   op_i        - ALUop code (see alu_op_e)
//   result_o    - operation result; 0 for undefined codes
//   zero_o      - result equals zero (forced 0 for undefined codes)
//   overflow_o  - signed overflow, ADD/SUB only
//   carry_o     - carry out of the adder, ADD/SUB only
//   err_o       - op_i is not a defined operation
module alu_issue_stage_alu
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned Width = AluDataWidth
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [Width-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             carry_o,
    output logic             err_o
);

    localparam int unsigned Msb = Width - 1;

    logic [Width:0] sum_ext;

    always_comb begin
        sum_ext    = '0;
        result_o   = '0;
        overflow_o = 1'b0;
        carry_o    = 1'b0;
        err_o      = 1'b0;
        case (op_i)
            AluAnd: result_o = a_i & b_i;
            AluOr:  result_o = a_i | b_i;
            AluAdd: begin
                sum_ext    = {1'b0, a_i} + {1'b0, b_i};
                result_o   = sum_ext[Width-1:0];
                carry_o    = sum_ext[Width];
                overflow_o = (a_i[Msb] == b_i[Msb]) && (result_o[Msb] != a_i[Msb]);
            end
            AluSub: begin
                // A - B as A + ~B + 1; carry set means no borrow.
                sum_ext    = {1'b0, a_i} + {1'b0, ~b_i} + {{Width{1'b0}}, 1'b1};
                result_o   = sum_ext[Width-1:0];
                carry_o    = sum_ext[Width];
                overflow_o = (a_i[Msb] != b_i[Msb]) && (result_o[Msb] != a_i[Msb]);
            end
            AluSlt: result_o = {{(Width-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: err_o = 1'b1;
        endcase
        zero_o = !err_o && (result_o == '0);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: a small operand FIFO feeding a combinational ALU whose result
// and flags are registered in a single output slot with valid/ready handshakes.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   in_valid/in_ready          - upstream handshake
//   in_A, in_B, in_ALUop       - operation pushed into the FIFO
//   out_valid/out_ready        - downstream handshake
//   out_Result, out_Zero,
//   out_Overflow, out_CarryOut - registered ALU result and flags
//   out_err                    - registered operation had an undefined ALUop
//   op_count                   - completed output handshakes (wraps at 16 bits)
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AluDataWidth,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_A,
    input  logic [DATA_WIDTH-1:0] in_B,
    input  logic [2:0]            in_ALUop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_Result,
    output logic                  out_Zero,
    output logic                  out_Overflow,
    output logic                  out_CarryOut,
    output logic                  out_err,
    output logic [15:0]           op_count
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [0:0] SlotEmpty = 1'b0;
    localparam logic [0:0] SlotFull  = 1'b1;

    // Operand FIFO storage (datapath only, no reset needed).
    logic [DATA_WIDTH-1:0] fifo_a_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_b_q  [FIFO_DEPTH];
    logic [2:0]            fifo_op_q [FIFO_DEPTH];

    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  ovf_q, ovf_d;
    logic                  carry_q, carry_d;
    logic                  err_q, err_d;
    logic [15:0]           op_count_q, op_count_d;

    logic                  push;
    logic                  capture;
    logic                  out_hs;
    logic                  fifo_empty;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_ovf;
    logic                  alu_carry;
    logic                  alu_err;

    // Readiness depends only on occupancy, so a full FIFO never accepts even
    // when the head is being popped in the same cycle.
    assign in_ready   = !rst && (count_q < CntW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count_q == '0);
    assign capture    = !fifo_empty && ((state_q == SlotEmpty) || out_ready);
    assign out_hs     = out_valid && out_ready;

    alu_issue_stage_alu #(
        .Width(DATA_WIDTH)
    ) u_alu (
        .a_i        (fifo_a_q[rd_ptr_q]),
        .b_i        (fifo_b_q[rd_ptr_q]),
        .op_i       (fifo_op_q[rd_ptr_q]),
        .result_o   (alu_result),
        .zero_o     (alu_zero),
        .overflow_o (alu_ovf),
        .carry_o    (alu_carry),
        .err_o      (alu_err)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (capture) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({push, capture})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        carry_d  = carry_q;
        err_d    = err_q;
        if (capture) begin
            state_d  = SlotFull;
            result_d = alu_result;
            zero_d   = alu_zero;
            ovf_d    = alu_ovf;
            carry_d  = alu_carry;
            err_d    = alu_err;
        end else if ((state_q == SlotFull) && out_ready) begin
            state_d = SlotEmpty;
        end
        op_count_d = out_hs ? op_count_q + 16'd1 : op_count_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q]  <= in_A;
            fifo_b_q[wr_ptr_q]  <= in_B;
            fifo_op_q[wr_ptr_q] <= in_ALUop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= SlotEmpty;
            result_q   <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            carry_q    <= carry_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
        end
    end

    // Outputs are masked while rst is high so a stale slot never shows as
    // valid (or handshakes) in the cycle reset is applied.
    assign out_valid    = (state_q == SlotFull) && !rst;
    assign out_Result   = rst ? '0 : result_q;
    assign out_Zero     = zero_q && !rst;
    assign out_Overflow = ovf_q && !rst;
    assign out_CarryOut = carry_q && !rst;
    assign out_err      = err_q && !rst;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [2:0]  in_ALUop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_Result;
    logic        out_Zero;
    logic        out_Overflow;
    logic        out_CarryOut;
    logic        out_err;
    logic [15:0] op_count;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b110;
    localparam logic [2:0] OpSlt = 3'b111;
    localparam logic [2:0] OpBad = 3'b011;

    alu_issue_stage #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_A         (in_A),
        .in_B         (in_B),
        .in_ALUop     (in_ALUop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_Result   (out_Result),
        .out_Zero     (out_Zero),
        .out_Overflow (out_Overflow),
        .out_CarryOut (out_CarryOut),
        .out_err      (out_err),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_A = '0; in_B = '0; in_ALUop = OpAnd;
        step();
        step();
        rst = 1'b0;
    endtask

    // Offer one op, then leave the result sitting in the output slot.
    task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        in_A = a; in_B = b; in_ALUop = op; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic push_three_held();
        out_ready = 1'b0;
        in_valid = 1'b1; in_A = 32'd1; in_B = 32'd1; in_ALUop = OpAdd;
        step();
        in_A = 32'd2; in_B = 32'd2;
        step();
        in_A = 32'd3; in_B = 32'd3;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_A = '0; in_B = '0; in_ALUop = OpAnd;
        #1;
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if ({out_valid, out_Zero, out_Overflow, out_CarryOut, out_err} !== 5'b0) begin
            n_fail++; $display("FAIL post_rst_flags: got %b expected 00000",
                               {out_valid, out_Zero, out_Overflow, out_CarryOut, out_err}); end
        n_cmp++; if (out_Result !== 32'd0) begin n_fail++; $display("FAIL post_rst_result: got %h expected 0", out_Result); end
        n_cmp++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL post_rst_count: got %0d expected 0", op_count); end
    endtask

    task automatic test_single();
        in_A = 32'd5; in_B = 32'd3; in_ALUop = OpAdd; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b expected 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_Result !== 32'd8) begin n_fail++; $display("FAIL single_result: got %h expected 8", out_Result); end
        n_cmp++; if ({out_Zero, out_Overflow, out_CarryOut, out_err} !== 4'b0) begin
            n_fail++; $display("FAIL single_flags: got %b expected 0000",
                               {out_Zero, out_Overflow, out_CarryOut, out_err}); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b expected 0", out_valid); end
        n_cmp++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", op_count); end
    endtask

    task automatic test_arith();
        run_single(32'h7FFF_FFFF, 32'd1, OpAdd);
        n_cmp++; if (out_Result !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_result: got %h expected 80000000", out_Result); end
        n_cmp++; if (out_Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", out_Overflow); end
        step();
        run_single(32'd3, 32'd3, OpSub);
        n_cmp++; if (out_Result !== 32'd0) begin n_fail++; $display("FAIL sub_result: got %h expected 0", out_Result); end
        n_cmp++; if ({out_Zero, out_Overflow} !== 2'b10) begin n_fail++; $display("FAIL sub_flags: got %b expected 10", {out_Zero, out_Overflow}); end
        step();
        run_single(32'hFFFF_FFFF, 32'd1, OpAdd);
        n_cmp++; if ({out_Result, out_Zero, out_Overflow, out_CarryOut} !== {32'd0, 3'b101}) begin
            n_fail++; $display("FAIL add_carry: got %h/%b expected 0/101",
                               out_Result, {out_Zero, out_Overflow, out_CarryOut}); end
        step();
        run_single(32'hFFFF_FFFF, 32'd1, OpSlt);
        n_cmp++; if (out_Result !== 32'd1) begin n_fail++; $display("FAIL slt_lt: got %h expected 1", out_Result); end
        step();
        run_single(32'd5, 32'hFFFF_FFFE, OpSlt);
        n_cmp++; if ({out_Result, out_Zero, out_Overflow, out_CarryOut} !== {32'd0, 3'b100}) begin
            n_fail++; $display("FAIL slt_ge: got %h/%b expected 0/100",
                               out_Result, {out_Zero, out_Overflow, out_CarryOut}); end
        step();
        run_single(32'h0000_F0F0, 32'h0000_FF00, OpAnd);
        n_cmp++; if (out_Result !== 32'h0000_F000) begin n_fail++; $display("FAIL and_result: got %h expected f000", out_Result); end
        step();
        run_single(32'h0000_F0F0, 32'h0000_FF00, OpOr);
        n_cmp++; if (out_Result !== 32'h0000_FFF0) begin n_fail++; $display("FAIL or_result: got %h expected fff0", out_Result); end
        step();
    endtask

    task automatic test_undefined();
        run_single(32'd5, 32'd3, OpBad);
        n_cmp++; if ({out_valid, out_err} !== 2'b11) begin n_fail++; $display("FAIL undef_err: got %b expected 11", {out_valid, out_err}); end
        n_cmp++; if ({out_Result, out_Zero, out_Overflow, out_CarryOut} !== 35'd0) begin
            n_fail++; $display("FAIL undef_result: got %h/%b expected 0/000",
                               out_Result, {out_Zero, out_Overflow, out_CarryOut}); end
        step();
        run_single(32'd1, 32'd2, OpAdd);
        n_cmp++; if ({out_err, out_Result} !== {1'b0, 32'd3}) begin
            n_fail++; $display("FAIL undef_recover: got %b/%h expected 0/3", out_err, out_Result); end
        step();
    endtask

    task automatic test_backpressure();
        apply_reset();
        push_three_held();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b expected 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({out_valid, out_Result} !== {1'b1, 32'd2}) begin
                n_fail++; $display("FAIL bp_hold: got %b/%h expected 1/2", out_valid, out_Result); end
            step();
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_pop_no_accept: got %b expected 0", in_ready); end
        step();
        n_cmp++; if ({out_valid, out_Result} !== {1'b1, 32'd4}) begin
            n_fail++; $display("FAIL bp_second: got %b/%h expected 1/4", out_valid, out_Result); end
        step();
        n_cmp++; if ({out_valid, out_Result} !== {1'b1, 32'd6}) begin
            n_fail++; $display("FAIL bp_third: got %b/%h expected 1/6", out_valid, out_Result); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
        n_cmp++; if (op_count !== 16'd3) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", op_count); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_A = i; in_B = 32'd100; in_ALUop = OpAdd; in_valid = 1'b1;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready); end
            step();
            if (i > 0) begin
                n_cmp++; if ({out_valid, out_Result} !== {1'b1, 32'(i + 99)}) begin
                    n_fail++; $display("FAIL stream_out[%0d]: got %b/%h expected 1/%h",
                                       i, out_valid, out_Result, 32'(i + 99)); end
            end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if ({out_valid, out_Result} !== {1'b1, 32'd119}) begin
            n_fail++; $display("FAIL stream_last: got %b/%h expected 1/77", out_valid, out_Result); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
        n_cmp++; if (op_count !== 16'd20) begin n_fail++; $display("FAIL stream_count: got %0d expected 20", op_count); end
    endtask

    task automatic test_reset_midstream();
        push_three_held();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_during_valid: got %b expected 0", out_valid); end
        step();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL mid_after: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        n_cmp++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", op_count); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if ({out_valid, out_Result, op_count} !== 49'd0) begin
                n_fail++; $display("FAIL mid_stale[%0d]: got %b/%h/%0d expected 0/0/0",
                                   i, out_valid, out_Result, op_count); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arith();
        test_undefined();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
